// File: rtl/fp_add_arbiter_if.sv
// Bundle for the shared FP adder arbiter: requester jobs,
// adder operand/result path and the tagged response channel.
interface fp_add_arbiter_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;

  logic [XLEN-1:0]      add_a;
  logic [XLEN-1:0]      add_b;
  logic [XLEN-1:0]      add_result;
  logic                 add_overflow;
  logic                 add_underflow;
  logic                 add_exception;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [XLEN-1:0]      rsp_result;
  logic [2:0]           rsp_flags;

  logic                 busy;
  logic [15:0]          op_count;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output add_result, add_overflow,
    output add_underflow, add_exception,
    output rsp_ready,
    input  req_ready, add_a, add_b,
    input  rsp_valid, rsp_id, rsp_result,
    input  rsp_flags, busy, op_count
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  add_result, add_overflow,
    input  add_underflow, add_exception,
    input  rsp_ready,
    output req_ready, add_a, add_b,
    output rsp_valid, rsp_id, rsp_result,
    output rsp_flags, busy, op_count
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational FP adder among
// NREQ requesters; one job in flight, tagged registered response.
module fp_add_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  fp_add_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [IDW-1:0]  r_rr;
  logic [IDW-1:0]  r_id;
  logic [XLEN-1:0] r_add_a;
  logic [XLEN-1:0] r_add_b;
  logic [XLEN-1:0] r_result;
  logic [2:0]      r_flags;
  logic [15:0]     r_op_count;

  logic            w_found;
  logic [IDW-1:0]  w_gidx;
  logic            w_take;
  logic            w_cap;
  logic            w_done;
  logic [XLEN-1:0] w_sel_a;
  logic [XLEN-1:0] w_sel_b;
  logic            w_sel_op;
  logic [IDW-1:0]  w_rr_next;

  // (base + k) mod NREQ without relying on NREQ being a power of 2
  function automatic logic [IDW-1:0] wrap_add(
    input logic [IDW-1:0] base,
    input int             k
  );
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // first valid requester at or above the rr pointer, circularly
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && bus.req_valid[wrap_add(r_rr, k)]) begin
        w_found = 1'b1;
        w_gidx  = wrap_add(r_rr, k);
      end
    end
  end

  // operand mux for the granted requester; sub flips B's sign
  always_comb begin
    w_sel_a   = bus.req_a[w_gidx*XLEN +: XLEN];
    w_sel_b   = bus.req_b[w_gidx*XLEN +: XLEN];
    w_sel_op  = bus.req_op[w_gidx];
    w_rr_next = wrap_add(w_gidx, 1);
  end

  // next state and one-cycle strobes
  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_cap  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_take = 1'b1;
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_cap  = 1'b1;
        w_next = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // grant capture: operands, tag and rr pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr    <= '0;
      r_id    <= '0;
      r_add_a <= '0;
      r_add_b <= '0;
    end else if (w_take) begin
      r_rr    <= w_rr_next;
      r_id    <= w_gidx;
      r_add_a <= w_sel_a;
      r_add_b <= {w_sel_b[XLEN-1] ^ w_sel_op,
                  w_sel_b[XLEN-2:0]};
    end
  end

  // adder result capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_cap) begin
      r_result <= bus.add_result;
      r_flags  <= {bus.add_exception,
                   bus.add_underflow,
                   bus.add_overflow};
    end
  end

  // completed-job counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst)         r_op_count <= '0;
    else if (w_done) r_op_count <= r_op_count + 16'd1;
  end

  assign bus.req_ready  = (w_take && !rst)
                        ? (NREQ'(1) << w_gidx)
                        : '0;
  assign bus.add_a      = r_add_a;
  assign bus.add_b      = r_add_b;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_result;
  assign bus.rsp_flags  = r_flags;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.op_count   = r_op_count;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter; the bench plays the adder
// by driving hand-computed sums while the job sits in EXEC.
module tb_fp_add_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_add_arbiter_if bus ();

  fp_add_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(
    input int          i,
    input logic        op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    bus.req_op[i]         = op;
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
  endtask

  task automatic adder(
    input logic [31:0] r,
    input logic [2:0]  f
  );
    bus.add_result    = r;
    bus.add_exception = f[2];
    bus.add_underflow = f[1];
    bus.add_overflow  = f[0];
  endtask

  logic [3:0] exp_rdy;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    adder(32'h0, 3'b000);
    set_req(0, 1'b0, 32'h3F800000, 32'h40000000);
    bus.req_valid = 4'b0001;

    // reset state; a valid request must not see ready in rst
    tick();
    #1;
    chk("rst_ready",  32'(bus.req_ready),  32'h0);
    chk("rst_rvalid", 32'(bus.rsp_valid),  32'h0);
    chk("rst_busy",   32'(bus.busy),       32'h0);
    chk("rst_add_a",  bus.add_a,           32'h0);
    chk("rst_add_b",  bus.add_b,           32'h0);
    chk("rst_cnt",    32'(bus.op_count),   32'h0);
    chk("rst_id",     32'(bus.rsp_id),     32'h0);
    chk("rst_res",    bus.rsp_result,      32'h0);
    chk("rst_flags",  32'(bus.rsp_flags),  32'h0);
    tick();
    rst = 1'b0;

    // single add: 1.0 + 2.0 from requester 0
    #1;
    chk("add_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    adder(32'h40400000, 3'b000);
    #1;
    chk("add_a",      bus.add_a,          32'h3F800000);
    chk("add_b",      bus.add_b,          32'h40000000);
    chk("add_busy",   32'(bus.busy),      32'h1);
    chk("add_rv_ex",  32'(bus.rsp_valid), 32'h0);
    chk("add_rdy_ex", 32'(bus.req_ready), 32'h0);
    tick();
    #1;
    chk("add_rvalid", 32'(bus.rsp_valid), 32'h1);
    chk("add_id",     32'(bus.rsp_id),    32'h0);
    chk("add_res",    bus.rsp_result,     32'h40400000);
    chk("add_flags",  32'(bus.rsp_flags), 32'h0);
    tick();
    #1;
    chk("add_done_rv", 32'(bus.rsp_valid), 32'h0);
    chk("add_cnt",     32'(bus.op_count),  32'h1);
    chk("add_idle",    32'(bus.busy),      32'h0);

    // subtract 3.0 - 1.0 from requester 2, then backpressure
    set_req(2, 1'b1, 32'h40400000, 32'h3F800000);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    #1;
    chk("sub_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b1111;
    adder(32'h40000000, 3'b101);
    #1;
    chk("sub_add_a",  bus.add_a,          32'h40400000);
    chk("sub_add_b",  bus.add_b,          32'hBF800000);
    chk("sub_rdy_ex", 32'(bus.req_ready), 32'h0);
    tick();
    adder(32'hDEADBEEF, 3'b000);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rvalid", 32'(bus.rsp_valid), 32'h1);
      chk("bp_id",     32'(bus.rsp_id),    32'h2);
      chk("bp_res",    bus.rsp_result,     32'h40000000);
      chk("bp_flags",  32'(bus.rsp_flags), 32'h5);
      chk("bp_ready",  32'(bus.req_ready), 32'h0);
      chk("bp_cnt",    32'(bus.op_count),  32'h1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_cnt_rel", 32'(bus.op_count), 32'h2);
    chk("bp_rv_rel",  32'(bus.rsp_valid), 32'h0);
    // rr sits at 3 after granting 2
    chk("rr_after_2", 32'(bus.req_ready), 32'h8);

    // reset wins over this pending grant and clears rr
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rr_rst_busy", 32'(bus.busy),     32'h0);
    chk("rr_rst_cnt",  32'(bus.op_count), 32'h0);

    // round robin with all four held valid: 0,1,2,3,0
    for (int j = 0; j < 5; j++) begin
      exp_rdy = 4'b0001 << (j % 4);
      #1;
      chk("rr_grant", 32'(bus.req_ready), 32'(exp_rdy));
      tick();
      adder(32'h10000000 + 32'(j), 3'b000);
      #1;
      chk("rr_busy", 32'(bus.busy), 32'h1);
      tick();
      #1;
      chk("rr_id",  32'(bus.rsp_id), 32'(j % 4));
      chk("rr_res", bus.rsp_result,  32'h10000000 + 32'(j));
      tick();
    end
    #1;
    chk("rr_cnt", 32'(bus.op_count), 32'h5);

    // reset mid-op: job from requester 1 is dropped
    chk("mid_grant", 32'(bus.req_ready), 32'h2);
    tick();
    adder(32'h7F000000, 3'b111);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'h1);
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("mid_rvalid", 32'(bus.rsp_valid), 32'h0);
    chk("mid_busy0",  32'(bus.busy),      32'h0);
    chk("mid_cnt",    32'(bus.op_count),  32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_norsp", 32'(bus.rsp_valid), 32'h0);
    end
    bus.req_valid = 4'b1111;
    #1;
    chk("mid_rr0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    adder(32'h3F800000, 3'b000);
    tick();
    #1;
    chk("mid_id", 32'(bus.rsp_id), 32'h0);
    tick();
    #1;
    chk("mid_cnt1", 32'(bus.op_count), 32'h1);

    // counter wrap from 0xFFFF
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    #1;
    chk("wrap_pre", 32'(bus.op_count), 32'hFFFF);
    tick();
    bus.req_valid = 4'b0001;
    #1;
    chk("wrap_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tick();
    #1;
    chk("wrap_rv", 32'(bus.rsp_valid), 32'h1);
    tick();
    #1;
    chk("wrap_cnt", 32'(bus.op_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
